// File: rtl/mult_div_unit.sv
// Iterative 32-bit unsigned multiply/divide unit with register-file writeback.
// One radix-2 step per clock; the result is written back 32 edges after acceptance.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [4:0]       dest_addr,
    output logic             busy,
    output logic             wb_enable,
    output logic [4:0]       wb_address,
    output logic [WIDTH-1:0] wb_data
);

    // state  | meaning
    // S_IDLE | waiting for start, operands may be accepted
    // S_CALC | 32 shift-add / restoring-divide iterations
    // S_DONE | one-cycle writeback strobe
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q;
    logic [1:0]       op_q;
    logic [4:0]       dest_q;
    logic [WIDTH-1:0] b_q, hi_q, lo_q;
    logic [WIDTH-1:0] hi_d, lo_d, result;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             accept, last_iter;

    assign accept    = (state_q == S_IDLE) && start;
    assign last_iter = (state_q == S_CALC) && (cnt_q == 6'd31);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (cnt_q == 6'd31) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // hi/lo hold {product high, multiplier/product low} or {remainder, quotient}.
    // The 34-bit difference keeps a zero divisor from looking negative, so
    // divide-by-zero naturally yields an all-ones quotient and remainder = dividend.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (op_q[1]) begin
            if (!div_diff[WIDTH+1]) begin
                hi_d = div_diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = div_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        result = op_q[0] ? hi_d : lo_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            op_q   <= '0;
            dest_q <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (accept) begin
            cnt_q  <= '0;
            op_q   <= op;
            dest_q <= dest_addr;
            b_q    <= src_b;
            hi_q   <= '0;
            lo_q   <= src_a;
        end else if (state_q == S_CALC) begin
            cnt_q <= cnt_q + 6'd1;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            wb_enable  <= 1'b0;
            wb_address <= '0;
            wb_data    <= '0;
        end else begin
            busy      <= (state_d != S_IDLE);
            wb_enable <= last_iter && (dest_q != 5'd0);
            if (last_iter) begin
                wb_data    <= result;
                wb_address <= dest_q;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: result values, latency, busy window,
// ignored restarts, dest 0 suppression and asynchronous abort.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic [4:0]  dest_addr;
    logic        busy, wb_enable;
    logic [4:0]  wb_address;
    logic [31:0] wb_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .dest_addr  (dest_addr),
        .busy       (busy),
        .wb_enable  (wb_enable),
        .wb_address (wb_address),
        .wb_data    (wb_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Launch one op, watch 40 edges after acceptance. inject_at > 0 raises
    // start with different op/dest just before that edge (must be ignored).
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d,
                          input logic [31:0] exp, input int inject_at);
        int en_cnt, en_edge, busy_fall;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; dest_addr = d;
        @(posedge clk); #1;
        start = 1'b0; src_a = ~a; src_b = ~b;
        check({tag, " busy_after_e0"}, 32'(busy), 32'd1);
        en_cnt = 0; en_edge = -1; busy_fall = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == inject_at) begin
                start = 1'b1; op = ~o; dest_addr = 5'd31;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (wb_enable) begin en_cnt++; en_edge = n; end
            if (busy_fall < 0 && !busy) busy_fall = n;
            if (n == 32) begin
                check({tag, " wb_data"}, wb_data, exp);
                check({tag, " wb_address"}, 32'(wb_address), 32'(d));
            end
        end
        check({tag, " busy_fall_edge"}, 32'(busy_fall), 32'd33);
        check({tag, " wb_enable_pulses"}, 32'(en_cnt), (d != 5'd0) ? 32'd1 : 32'd0);
        if (d != 5'd0) check({tag, " wb_enable_edge"}, 32'(en_edge), 32'd32);
        check({tag, " wb_data_held"}, wb_data, exp);
    endtask

    initial begin
        int en_cnt;
        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; dest_addr = '0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset wb_enable", 32'(wb_enable), 32'd0);
        check("reset wb_address", 32'(wb_address), 32'd0);
        check("reset wb_data", wb_data, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        run_op("mul_7x6",    2'b00, 32'd7,          32'd6,          5'd3,  32'd42,         0);
        run_op("mul_ff",     2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0001,  0);
        run_op("mulhu_ff",   2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  0);
        run_op("divu_100_7", 2'b10, 32'd100,        32'd7,          5'd4,  32'd14,         0);
        run_op("remu_100_7", 2'b11, 32'd100,        32'd7,          5'd5,  32'd2,          0);
        run_op("divu_5_0",   2'b10, 32'd5,          32'd0,          5'd6,  32'hFFFF_FFFF,  0);
        run_op("remu_5_0",   2'b11, 32'd5,          32'd0,          5'd7,  32'd5,          0);
        run_op("mulhu_big",  2'b01, 32'h8000_0000,  32'd6,          5'd8,  32'd3,          0);
        run_op("mul_3x4_inj",2'b00, 32'd3,          32'd4,          5'd9,  32'd12,         5);
        run_op("divu_dest0", 2'b10, 32'd9,          32'd2,          5'd0,  32'd4,          0);

        // Abort a DIVU between E10 and E11; start held during reset must be ignored.
        @(negedge clk);
        start = 1'b1; op = 2'b10; src_a = 32'd100; src_b = 32'd7; dest_addr = 5'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort wb_enable", 32'(wb_enable), 32'd0);
        check("abort wb_address", 32'(wb_address), 32'd0);
        check("abort wb_data", wb_data, 32'd0);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("start_in_reset busy", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b0; start = 1'b0;
        en_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (wb_enable || busy) en_cnt++;
        end
        check("abort no_activity", 32'(en_cnt), 32'd0);
        run_op("mul_2x3_after_abort", 2'b00, 32'd2, 32'd3, 5'd11, 32'd6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, and SHALL name these ports clk and rst.
REQ-002 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-003 clk  input  1  rising-edge clock for all block state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request a new operation; sampled on the rising clk edge.
REQ-006 op  input  2  operation: 00 MUL (low 32 bits), 01 MULHU (high 32 bits, unsigned), 10 DIVU (quotient), 11 REMU (remainder).
REQ-007 src_a  input  32  operand A (multiplicand or dividend), driven from register-file read port 1.
REQ-008 src_b  input  32  operand B (multiplier or divisor), driven from register-file read port 2.
REQ-009 dest_addr  input  5  destination register for the result.
REQ-010 busy  output  1  high from acceptance until return to IDLE.
REQ-011 wb_enable  output  1  one-cycle write strobe to the register-file write port.
REQ-012 wb_address  output  5  write address to the register file.
REQ-013 wb_data  output  32  result written to the register file.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-015 IDLE: start=1 at rising edge E0 latches op, src_a, src_b and dest_addr, clears the iteration counter, and moves to CALC; busy=1 after E0.
REQ-016 start SHALL be ignored in CALC and DONE, with no effect on the latched operands.
REQ-017 CALC: one radix-2 iteration per edge over 32 edges (E1..E32); the 6-bit counter reaches 32, then the FSM moves to DONE after E32.
REQ-018 Multiply: unsigned shift-add with a 64-bit product; MUL returns product[31:0] and MULHU returns product[63:32].
REQ-019 Divide: unsigned restoring division; DIVU returns the quotient and REMU returns the remainder.
REQ-020 Divisor 0: quotient SHALL be 0xFFFFFFFF and remainder SHALL be src_a, with the full 33-cycle latency retained.
REQ-021 DONE lasts exactly one cycle (E32..E33): wb_data = result, wb_address = latched dest_addr, and wb_enable = 1 only if dest_addr != 0; after E33 the FSM returns to IDLE and busy=0.
REQ-022 Latency: wb_enable SHALL be high in the cycle following edge E32 (32 edges after the accepting edge E0); the next start can be accepted at E33 at the earliest.
REQ-023 All outputs SHALL be registered and change only on the rising clk edge, so they are stable at the register file's falling-edge write.
REQ-024 wb_data and wb_address SHALL hold their last values outside DONE; wb_enable SHALL be 0 outside DONE.
REQ-025 Operands SHALL be latched at acceptance, so src_a/src_b changes during CALC do not affect the result.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, busy=0, wb_enable=0, wb_address=0, wb_data=0, and clear the counter and datapath registers, independent of clk.
REQ-027 rst asserted during CALC or DONE SHALL abort the operation; no wb_enable pulse occurs for it after release.
REQ-028 start SHALL NOT be accepted on any edge while rst=1; the first acceptance is at the first rising edge with rst=0.

Verification
REQ-029 MUL src_a=7, src_b=6, dest_addr=3 -> busy high for 33 cycles; a single wb_enable pulse after E32 with wb_address=3 and wb_data=42.
REQ-030 MUL and MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> wb_data=0x00000001 and 0xFFFFFFFE respectively.
REQ-031 DIVU and REMU with 100 / 7 -> 14 and 2; DIVU and REMU with 5 / 0 -> 0xFFFFFFFF and 5.
REQ-032 start pulsed with new operands at E5 of a busy MUL 3x4 -> ignored, result 12; dest_addr=0 on any op -> busy completes and wb_enable never rises.
REQ-033 rst asserted mid-edge between E10 and E11 of DIVU -> all outputs 0 immediately; no wb_enable pulse; a fresh MUL 2x3 after release -> 6.
